// File: rtl/sirv_gnrl_pkg.sv
// Shared definitions for the generic register pipeline primitives:
// occupancy-counter width and the default reset value bit.
package sirv_gnrl_pkg;

    localparam logic DEF_RST_BIT = 1'b0;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/sirv_gnrl_pipe_stage.sv
// One valid/ready register stage: loads when upstream is valid and the slot is free
// or draining this cycle; clears its valid when data leaves without a reload.
module sirv_gnrl_pipe_stage
    import sirv_gnrl_pkg::*;
#(
    parameter int unsigned    DW      = 32,
    parameter logic [DW-1:0]  RST_VAL = {DW{DEF_RST_BIT}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          up_vld,
    input  logic [DW-1:0] up_dat,
    output logic          rdy_c,
    input  logic          dn_rdy,
    output logic          vld,
    output logic [DW-1:0] dat
);

    logic load;
    logic leave;

    assign rdy_c = !vld || dn_rdy;
    assign load  = up_vld && rdy_c;
    assign leave = vld && dn_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= 1'b0;
        end else if (flush) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= 1'b1;
        end else if (leave) begin
            vld <= 1'b0;
        end
    end

    // Payload only moves on an accepted load; flush leaves it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat <= RST_VAL;
        end else if (load && !flush) begin
            dat <= up_dat;
        end
    end

endmodule

// File: rtl/sirv_gnrl_pipe_dffr.sv
// Elastic DEPTH-stage valid/ready register pipeline with reset value, synchronous
// flush, occupancy count and an optional input skid buffer that registers i_rdy.
module sirv_gnrl_pipe_dffr
    import sirv_gnrl_pkg::*;
#(
    parameter int unsigned   DW        = 32,
    parameter int unsigned   DEPTH     = 1,
    parameter logic [DW-1:0] RST_VAL   = {DW{DEF_RST_BIT}},
    parameter int unsigned   CUT_READY = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          i_vld,
    output logic                          i_rdy,
    input  logic [DW-1:0]                 i_dat,
    output logic                          o_vld,
    input  logic                          o_rdy,
    output logic [DW-1:0]                 o_dat,
    output logic [cnt_width(DEPTH)-1:0]   cnt
);

    localparam int unsigned CW = cnt_width(DEPTH);

    if (DEPTH == 0) begin : g_bypass
        logic unused;
        assign unused = ^{clk, rst, flush};
        assign o_vld  = i_vld;
        assign o_dat  = i_dat;
        assign i_rdy  = o_rdy;
        assign cnt    = '0;
    end else begin : g_pipe
        logic          s0_vld;
        logic [DW-1:0] s0_dat;
        logic          s0_rdy;
        logic          in_acc;
        logic          out_acc;

        for (genvar k = 0; k < int'(DEPTH); k++) begin : g_st
            logic          up_vld;
            logic [DW-1:0] up_dat;
            logic          dn_rdy;
            logic          rdy;
            logic          vld;
            logic [DW-1:0] dat;

            if (k == 0) begin : g_first
                assign up_vld = s0_vld;
                assign up_dat = s0_dat;
            end else begin : g_mid
                assign up_vld = g_st[k-1].vld;
                assign up_dat = g_st[k-1].dat;
            end

            // Ready ripples back combinationally from o_rdy through every stage.
            if (k == int'(DEPTH) - 1) begin : g_last
                assign dn_rdy = o_rdy;
            end else begin : g_next
                assign dn_rdy = g_st[k+1].rdy;
            end

            sirv_gnrl_pipe_stage #(
                .DW      (DW),
                .RST_VAL (RST_VAL)
            ) u_stage (
                .clk    (clk),
                .rst    (rst),
                .flush  (flush),
                .up_vld (up_vld),
                .up_dat (up_dat),
                .rdy_c  (rdy),
                .dn_rdy (dn_rdy),
                .vld    (vld),
                .dat    (dat)
            );
        end

        assign s0_rdy = g_st[0].rdy;
        assign o_vld  = g_st[DEPTH-1].vld;
        assign o_dat  = g_st[DEPTH-1].dat;

        if (CUT_READY != 0) begin : g_skid
            logic          skid_vld;
            logic [DW-1:0] skid_dat;

            // A held skid entry feeds stage 0 ahead of new input.
            assign s0_vld = skid_vld || i_vld;
            assign s0_dat = skid_vld ? skid_dat : i_dat;
            assign i_rdy  = !skid_vld;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    skid_vld <= 1'b0;
                end else if (flush) begin
                    skid_vld <= 1'b0;
                end else if (skid_vld) begin
                    if (s0_rdy) begin
                        skid_vld <= 1'b0;
                    end
                end else if (i_vld && !s0_rdy) begin
                    skid_vld <= 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    skid_dat <= RST_VAL;
                end else if (!skid_vld && i_vld && !s0_rdy && !flush) begin
                    skid_dat <= i_dat;
                end
            end
        end else begin : g_noskid
            assign s0_vld = i_vld;
            assign s0_dat = i_dat;
            assign i_rdy  = s0_rdy;
        end

        // Occupancy tracks accepted-minus-delivered entries; flush empties everything.
        assign in_acc  = i_vld && i_rdy;
        assign out_acc = o_vld && o_rdy;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (flush) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(in_acc) - CW'(out_acc);
            end
        end
    end

endmodule

// File: tb/tb_sirv_gnrl_pipe_dffr.sv
// Self-checking bench: nine pipeline configurations, directed corner cases,
// a DEPTH=0 vector table and randomized handshakes against a queue model.
module tb_sirv_gnrl_pipe_dffr;

    localparam int NI = 9;
    localparam logic [31:0] RV = 32'hDEAD_BEEF;

    function automatic int unsigned dep_of(input int g);
        case (g)
            0, 1:    return 1;
            2, 3:    return 2;
            4, 5:    return 4;
            6, 7:    return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned cut_of(input int g);
        return (g == 1 || g == 3 || g == 5 || g == 7) ? 1 : 0;
    endfunction

    logic clk;
    logic rst;
    logic flush;
    logic [NI-1:0] i_vld_v;
    logic [NI-1:0] o_rdy_v;
    logic [31:0]   i_dat_a [NI];
    wire  [NI-1:0] i_rdy_v;
    wire  [NI-1:0] o_vld_v;
    wire  [31:0]   o_dat_a [NI];
    wire  [2:0]    cnt_a   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned D   = dep_of(g);
        localparam int unsigned C   = cut_of(g);
        localparam int unsigned CWL = $clog2(D + 2);
        wire [CWL-1:0] c;

        sirv_gnrl_pipe_dffr #(
            .DW        (32),
            .DEPTH     (D),
            .RST_VAL   (RV),
            .CUT_READY (C)
        ) u_dut (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .i_vld (i_vld_v[g]),
            .i_rdy (i_rdy_v[g]),
            .i_dat (i_dat_a[g]),
            .o_vld (o_vld_v[g]),
            .o_rdy (o_rdy_v[g]),
            .o_dat (o_dat_a[g]),
            .cnt   (c)
        );
        assign cnt_a[g] = 3'(c);
    end

    typedef struct {
        logic        v;
        logic        r;
        logic [31:0] d;
        logic        ev;
        logic        er;
        logic [31:0] ed;
    } comb_vec_t;

    comb_vec_t cv [6];
    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        flush   = 1'b0;
        i_vld_v = '0;
        o_rdy_v = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_random(input int g, input int n);
        logic [31:0] q[$];
        int          d;
        int          c;
        int          rdy_pct;
        logic        cur_v;
        logic        prev_stall;
        logic        drain;
        logic        exp_irdy;
        logic [31:0] cur_d;
        logic [31:0] prev_dat;
        logic [31:0] exp_d;
        d = int'(dep_of(g));
        c = int'(cut_of(g));
        cur_v = 1'b0;
        cur_d = '0;
        prev_stall = 1'b0;
        prev_dat = '0;
        rdy_pct = 50;
        do_reset();
        for (int t = 0; t < n + d + c + 4; t++) begin
            drain = (t >= n);
            if (t % 200 == 0) rdy_pct = ((t / 200) % 3 == 0) ? 50 : (((t / 200) % 3 == 1) ? 15 : 90);
            if (drain) cur_v = 1'b0;
            else if (!cur_v && $urandom_range(99) < 65) begin
                cur_v = 1'b1;
                cur_d = $urandom;
            end
            i_vld_v[g] = cur_v;
            i_dat_a[g] = cur_d;
            o_rdy_v[g] = drain ? 1'b1 : ($urandom_range(99) < rdy_pct);
            #2;
            check("rnd_cnt", 32'(cnt_a[g]), 32'(q.size()));
            // No skid: ready whenever any stage is empty or the output drains.
            exp_irdy = (c != 0) ? (q.size() <= d) : ((q.size() < d) || o_rdy_v[g]);
            check("rnd_i_rdy", 32'(i_rdy_v[g]), 32'(exp_irdy));
            if (prev_stall) begin
                check("rnd_hold_vld", 32'(o_vld_v[g]), 32'd1);
                check("rnd_hold_dat", o_dat_a[g], prev_dat);
            end
            if (o_vld_v[g] && o_rdy_v[g]) begin
                if (q.size() == 0) begin
                    check("rnd_spurious_vld", 32'(o_vld_v[g]), 32'd0);
                end else begin
                    exp_d = q.pop_front();
                    check("rnd_data", o_dat_a[g], exp_d);
                end
            end
            if (cur_v && i_rdy_v[g]) begin
                q.push_back(cur_d);
                cur_v = 1'b0;
            end
            prev_stall = o_vld_v[g] && !o_rdy_v[g];
            prev_dat   = o_dat_a[g];
            @(negedge clk);
        end
        check("rnd_drained", 32'(q.size()), 32'd0);
        i_vld_v[g] = 1'b0;
        o_rdy_v[g] = 1'b0;
    endtask

    initial begin
        int          acc;
        int          seen;
        logic [31:0] got [$];
        checks   = 0;
        failures = 0;
        cv[0] = '{v: 1'b0, r: 1'b0, d: 32'h0000_1234, ev: 1'b0, er: 1'b0, ed: 32'h0000_1234};
        cv[1] = '{v: 1'b1, r: 1'b0, d: 32'hA5A5_A5A5, ev: 1'b1, er: 1'b0, ed: 32'hA5A5_A5A5};
        cv[2] = '{v: 1'b0, r: 1'b1, d: 32'h5A5A_5A5A, ev: 1'b0, er: 1'b1, ed: 32'h5A5A_5A5A};
        cv[3] = '{v: 1'b1, r: 1'b1, d: 32'hFFFF_FFFF, ev: 1'b1, er: 1'b1, ed: 32'hFFFF_FFFF};
        cv[4] = '{v: 1'b1, r: 1'b1, d: 32'h0000_0000, ev: 1'b1, er: 1'b1, ed: 32'h0000_0000};
        cv[5] = '{v: 1'b0, r: 1'b0, d: 32'h8000_0001, ev: 1'b0, er: 1'b0, ed: 32'h8000_0001};
        for (int g = 0; g < NI; g++) i_dat_a[g] = '0;

        // Reset state of every registered configuration.
        rst = 1'b1;
        flush = 1'b0;
        i_vld_v = '0;
        o_rdy_v = '0;
        @(negedge clk);
        #2;
        for (int g = 0; g < NI - 1; g++) begin
            check("rst_o_vld", 32'(o_vld_v[g]), 32'd0);
            check("rst_o_dat", o_dat_a[g], RV);
            check("rst_cnt", 32'(cnt_a[g]), 32'd0);
            check("rst_i_rdy", 32'(i_rdy_v[g]), 32'd1);
        end
        @(negedge clk);
        rst = 1'b0;

        // DEPTH=0 combinational pass-through vectors.
        for (int i = 0; i < 6; i++) begin
            i_vld_v[8] = cv[i].v;
            o_rdy_v[8] = cv[i].r;
            i_dat_a[8] = cv[i].d;
            #2;
            check("d0_o_vld", 32'(o_vld_v[8]), 32'(cv[i].ev));
            check("d0_i_rdy", 32'(i_rdy_v[8]), 32'(cv[i].er));
            check("d0_o_dat", o_dat_a[8], cv[i].ed);
            check("d0_cnt", 32'(cnt_a[8]), 32'd0);
            @(negedge clk);
        end
        i_vld_v[8] = 1'b0;
        o_rdy_v[8] = 1'b0;

        // Streaming DEPTH=3: 1..10 back-to-back, first output at cycle 3.
        do_reset();
        for (int t = 0; t < 15; t++) begin
            i_vld_v[6] = (t < 10);
            i_dat_a[6] = 32'(t + 1);
            o_rdy_v[6] = 1'b1;
            #2;
            if (t < 10) check("str_i_rdy", 32'(i_rdy_v[6]), 32'd1);
            check("str_o_vld", 32'(o_vld_v[6]), 32'(t >= 3 && t <= 12));
            if (t >= 3 && t <= 12) check("str_o_dat", o_dat_a[6], 32'(t - 2));
            @(negedge clk);
        end
        i_vld_v[6] = 1'b0;

        // Back-pressure DEPTH=3 with skid: fills to 4, i_rdy drops after the 4th accept.
        do_reset();
        acc = 0;
        for (int t = 0; t < 8; t++) begin
            i_vld_v[7] = 1'b1;
            i_dat_a[7] = 32'(100 + acc);
            o_rdy_v[7] = 1'b0;
            #2;
            check("bp_cnt", 32'(cnt_a[7]), 32'((t < 4) ? t : 4));
            check("bp_i_rdy", 32'(i_rdy_v[7]), 32'(t < 4));
            if (t >= 3) check("bp_o_dat", o_dat_a[7], 32'd100);
            if (i_rdy_v[7]) acc++;
            @(negedge clk);
        end
        i_vld_v[7] = 1'b0;
        o_rdy_v[7] = 1'b1;
        got.delete();
        for (int t = 0; t < 10; t++) begin
            #2;
            if (o_vld_v[7]) got.push_back(o_dat_a[7]);
            @(negedge clk);
        end
        check("bp_drain_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < got.size(); i++) check("bp_drain_dat", got[i], 32'(100 + i));
        check("bp_drain_cnt", 32'(cnt_a[7]), 32'd0);

        // Asynchronous reset mid-stream takes effect immediately.
        o_rdy_v[7] = 1'b0;
        i_vld_v[7] = 1'b1;
        for (int t = 0; t < 3; t++) begin
            i_dat_a[7] = 32'(50 + t);
            @(negedge clk);
        end
        #1;
        rst = 1'b1;
        #1;
        check("mrst_o_vld", 32'(o_vld_v[7]), 32'd0);
        check("mrst_o_dat", o_dat_a[7], RV);
        check("mrst_cnt", 32'(cnt_a[7]), 32'd0);
        check("mrst_i_rdy", 32'(i_rdy_v[7]), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        i_vld_v[7] = 1'b0;

        // Flush with three entries held and a valid input in the flush cycle.
        do_reset();
        i_vld_v[7] = 1'b1;
        o_rdy_v[7] = 1'b0;
        for (int t = 0; t < 3; t++) begin
            i_dat_a[7] = 32'(200 + t);
            #2;
            check("fl_fill_i_rdy", 32'(i_rdy_v[7]), 32'd1);
            @(negedge clk);
        end
        flush = 1'b1;
        i_dat_a[7] = 32'h0000_0999;
        #2;
        check("fl_pre_cnt", 32'(cnt_a[7]), 32'd3);
        check("fl_i_rdy", 32'(i_rdy_v[7]), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        i_vld_v[7] = 1'b0;
        o_rdy_v[7] = 1'b1;
        #2;
        check("fl_cnt", 32'(cnt_a[7]), 32'd0);
        check("fl_o_vld", 32'(o_vld_v[7]), 32'd0);
        seen = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            #2;
            if (o_vld_v[7]) seen++;
        end
        check("fl_no_output", 32'(seen), 32'd0);
        @(negedge clk);
        o_rdy_v[7] = 1'b0;

        // Randomized handshakes on DEPTH 1/2/4 with and without skid.
        for (int g = 0; g < 6; g++) run_random(g, 1600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sirv_gnrl_pipe_dffr.md
# sirv_gnrl_pipe_dffr

Parametrised elastic register pipeline: the generalised successor of the plain reset-DFF primitive. Carries a DW-bit payload through DEPTH valid/ready-handshaked register stages, with a per-instance reset value, synchronous flush, occupancy count and an optional skid buffer that registers the upstream ready. Used wherever a core datapath needs retiming stages that tolerate downstream back-pressure, e.g. between IFU/EXU and the LSU/bus interfaces.

## Interface
Parameters:
- DW, 32, payload width in bits (≥1)
- DEPTH, 1, number of register stages (0 = combinational pass-through)
- RST_VAL, {DW{1'b0}}, reset value of every data register
- CUT_READY, 0, 1 = add input skid buffer so i_rdy is a flop output

Ports (one clock; reset asynchronous, active-high):
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous clear of all valid state
- i_vld  in  1  upstream payload valid
- i_rdy  out  1  block can accept payload
- i_dat  in  DW  upstream payload
- o_vld  out  1  output stage holds valid payload
- o_rdy  in  1  downstream accepts
- o_dat  out  DW  output payload
- cnt  out  CW  valid entries held, CW = $clog2(DEPTH+2)

## Operation
- Handshake: transfer on a port when vld & rdy in the same cycle. vld must not depend on rdy. Payload must stay stable while vld & !rdy (upstream obligation; block guarantees it on the output side).
- Stage k (0 = input side, DEPTH-1 = output): holds vld_k, dat_k. Stage k loads when its upstream offers valid data and (!vld_k | advance_{k+1}); advance at the last stage = o_rdy. A stage whose data leaves without reload clears vld_k. Data registers load only on accept; otherwise hold.
- Full throughput: one transfer per cycle sustained when o_rdy=1; ready propagates combinationally from o_rdy back through all stages when CUT_READY=0.
- CUT_READY=1: i_rdy = !skid_vld (register). Input goes straight to stage 0 if stage 0 can load; otherwise captured in skid. Skid drains to stage 0 with priority over i_dat. No added latency when skid is empty.
- DEPTH=0: o_vld=i_vld, o_dat=i_dat, i_rdy=o_rdy, cnt=0; CUT_READY ignored.
- flush: at the next edge all vld_k and skid_vld become 0; data registers untouched. Input handshake in a flush cycle is discarded; output handshake in a flush cycle still completes. i_rdy during flush follows normal rules.
- cnt = sum of vld_k plus skid_vld, registered alongside them; max DEPTH+CUT_READY.
- Reset: all vld, skid_vld = 0; all data and skid data = RST_VAL; hence o_vld=0, o_dat=RST_VAL, cnt=0, i_rdy=1 immediately on assertion. Reset mid-transfer discards all contents.

## Timing
- Latency i-handshake → o_vld: DEPTH cycles with no stalls.
- o_rdy low for N cycles with i_vld high: pipeline fills to DEPTH(+1 with skid) entries, then i_rdy=0 (same cycle when CUT_READY=0, next cycle when CUT_READY=1).
- Simultaneous accept and release at a full stage: both occur; occupancy unchanged.
- Bubbles collapse: an empty stage accepts even when o_rdy=0.
- Critical path with CUT_READY=0: o_rdy → i_rdy through DEPTH AND/OR levels.

## Structure
- Shared package sirv_gnrl_pkg: CW computation function and default RST_VAL constant.
- One sub-module sirv_gnrl_pipe_stage (single vld/dat stage with load/advance logic), instantiated DEPTH times in a generate loop; skid buffer and cnt logic in the top.

## Test plan
- Reset: rst=1 mid-stream with RST_VAL=32'hDEAD_BEEF → o_vld=0, o_dat=32'hDEADBEEF, cnt=0, i_rdy=1 immediately.
- Streaming DEPTH=3, o_rdy=1, inputs 1..10 back-to-back → outputs 1..10 in order, first at cycle 3, no bubbles.
- Back-pressure DEPTH=3, CUT_READY=1, o_rdy=0 → cnt reaches 4, i_rdy drops the cycle after the 4th accept, no data lost after o_rdy returns.
- Flush with cnt=3 and i_vld=1 → next cycle cnt=0, o_vld=0, flushed-cycle input never appears at output.
- DEPTH=0 → o_dat=i_dat, i_rdy=o_rdy combinationally, cnt=0.
- Random vld/rdy (10k cycles, DEPTH∈{1,2,4}, CUT_READY∈{0,1}) → scoreboard order-exact, payload stable while o_vld & !o_rdy.
